// File: rtl/userio_pattern_seq.sv
// Programmable pattern sequencer for the USERIO pad stage: plays back up to pDEPTH
// {data, oe, duration} steps, optionally looping, and drives idle values otherwise.
module userio_pattern_seq #(
    parameter int pWIDTH     = 8,
    parameter int pDEPTH     = 16,
    parameter int pDUR_WIDTH = 16,
    localparam int AW = $clog2(pDEPTH),
    localparam int NW = AW + 1
) (
    input  logic                  usb_clk,
    input  logic                  reset_n,
    input  logic                  I_wr_en,
    input  logic [AW-1:0]         I_wr_addr,
    input  logic [pWIDTH-1:0]     I_wr_data,
    input  logic [pWIDTH-1:0]     I_wr_oe,
    input  logic [pDUR_WIDTH-1:0] I_wr_dur,
    input  logic [NW-1:0]         I_num_steps,
    input  logic                  I_loop,
    input  logic                  I_start,
    input  logic                  I_stop,
    input  logic [pWIDTH-1:0]     I_idle_data,
    input  logic [pWIDTH-1:0]     I_idle_oe,
    output logic [pWIDTH-1:0]     O_userio_drive_data,
    output logic [pWIDTH-1:0]     O_userio_pwdriven,
    output logic                  O_busy,
    output logic [AW-1:0]         O_step,
    output logic                  O_done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [pWIDTH-1:0]     mem_data [pDEPTH];
    logic [pWIDTH-1:0]     mem_oe   [pDEPTH];
    logic [pDUR_WIDTH-1:0] mem_dur  [pDEPTH];

    logic [0:0]            state;
    logic [NW-1:0]         num_q;
    logic                  loop_q;
    logic [pDUR_WIDTH-1:0] dur_cnt;
    logic [NW-1:0]         start_num;
    logic                  at_last;
    logic [AW-1:0]         load_idx;

    function automatic logic [NW-1:0] clamp_steps(input logic [NW-1:0] n);
        clamp_steps = (n > NW'(pDEPTH)) ? NW'(pDEPTH) : n;
    endfunction

    // Counter start value: a zero duration still holds the step for one cycle.
    function automatic logic [pDUR_WIDTH-1:0] hold_init(input logic [pDUR_WIDTH-1:0] d);
        hold_init = (d == '0) ? '0 : d - pDUR_WIDTH'(1);
    endfunction

    always_ff @(posedge usb_clk) begin
        if (I_wr_en) begin
            mem_data[I_wr_addr] <= I_wr_data;
            mem_oe[I_wr_addr]   <= I_wr_oe;
            mem_dur[I_wr_addr]  <= I_wr_dur;
        end
    end

    always_comb begin
        start_num = clamp_steps(I_num_steps);
        at_last   = ({1'b0, O_step} == (num_q - NW'(1)));
        load_idx  = '0;
        if (state == ST_RUN && !at_last) begin
            load_idx = O_step + AW'(1);
        end
    end

    always_ff @(posedge usb_clk) begin
        if (!reset_n) begin
            state               <= ST_IDLE;
            O_userio_drive_data <= '0;
            O_userio_pwdriven   <= '0;
            O_busy              <= 1'b0;
            O_step              <= '0;
            O_done              <= 1'b0;
            dur_cnt             <= '0;
            num_q               <= '0;
            loop_q              <= 1'b0;
        end else begin
            O_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (I_start && !I_stop && start_num != '0) begin
                        state               <= ST_RUN;
                        O_busy              <= 1'b1;
                        num_q               <= start_num;
                        loop_q              <= I_loop;
                        O_userio_drive_data <= mem_data[load_idx];
                        O_userio_pwdriven   <= mem_oe[load_idx];
                        dur_cnt             <= hold_init(mem_dur[load_idx]);
                        O_step              <= load_idx;
                    end else begin
                        O_userio_drive_data <= I_idle_data;
                        O_userio_pwdriven   <= I_idle_oe;
                    end
                end
                default: begin
                    if (I_stop || (dur_cnt == '0 && at_last && !loop_q)) begin
                        // Abort and normal completion share the exit path; only completion pulses done.
                        state               <= ST_IDLE;
                        O_busy              <= 1'b0;
                        O_step              <= '0;
                        dur_cnt             <= '0;
                        O_done              <= !I_stop;
                        O_userio_drive_data <= I_idle_data;
                        O_userio_pwdriven   <= I_idle_oe;
                    end else if (dur_cnt != '0) begin
                        dur_cnt <= dur_cnt - pDUR_WIDTH'(1);
                    end else begin
                        O_userio_drive_data <= mem_data[load_idx];
                        O_userio_pwdriven   <= mem_oe[load_idx];
                        dur_cnt             <= hold_init(mem_dur[load_idx]);
                        O_step              <= load_idx;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_userio_pattern_seq.sv
// Directed bench for userio_pattern_seq: reset, one-shot, loop, stop/start corner cases,
// live rewrite during playback and step-count clamping.
module tb_userio_pattern_seq;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NW = 5;

    logic          usb_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          I_wr_en = 1'b0;
    logic [AW-1:0] I_wr_addr = '0;
    logic [W-1:0]  I_wr_data = '0;
    logic [W-1:0]  I_wr_oe = '0;
    logic [DW-1:0] I_wr_dur = '0;
    logic [NW-1:0] I_num_steps = '0;
    logic          I_loop = 1'b0;
    logic          I_start = 1'b0;
    logic          I_stop = 1'b0;
    logic [W-1:0]  I_idle_data = 8'hA5;
    logic [W-1:0]  I_idle_oe = 8'hFF;
    logic [W-1:0]  O_userio_drive_data;
    logic [W-1:0]  O_userio_pwdriven;
    logic          O_busy;
    logic [AW-1:0] O_step;
    logic          O_done;

    int total = 0;
    int bad   = 0;

    userio_pattern_seq #(.pWIDTH(W), .pDEPTH(D), .pDUR_WIDTH(DW)) dut (
        .usb_clk(usb_clk), .reset_n(reset_n),
        .I_wr_en(I_wr_en), .I_wr_addr(I_wr_addr), .I_wr_data(I_wr_data),
        .I_wr_oe(I_wr_oe), .I_wr_dur(I_wr_dur), .I_num_steps(I_num_steps),
        .I_loop(I_loop), .I_start(I_start), .I_stop(I_stop),
        .I_idle_data(I_idle_data), .I_idle_oe(I_idle_oe),
        .O_userio_drive_data(O_userio_drive_data), .O_userio_pwdriven(O_userio_pwdriven),
        .O_busy(O_busy), .O_step(O_step), .O_done(O_done)
    );

    always #5 usb_clk = ~usb_clk;

    task automatic tick();
        @(posedge usb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] data, input logic [7:0] oe,
                           input logic busy, input logic done);
        chk({tag, ".data"}, 32'(O_userio_drive_data), 32'(data));
        chk({tag, ".oe"},   32'(O_userio_pwdriven),   32'(oe));
        chk({tag, ".busy"}, 32'(O_busy),              32'(busy));
        chk({tag, ".done"}, 32'(O_done),              32'(done));
    endtask

    task automatic wr_step(input int idx, input logic [7:0] data, input logic [7:0] oe,
                           input logic [15:0] dur);
        I_wr_addr = AW'(idx);
        I_wr_data = data;
        I_wr_oe   = oe;
        I_wr_dur  = dur;
        I_wr_en   = 1'b1;
        tick();
        I_wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        I_start = 1'b1;
        tick();
        I_start = 1'b0;
    endtask

    initial begin
        // Test 1: reset
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("rst", 8'h00, 8'h00, 1'b0, 1'b0);
            chk("rst.step", 32'(O_step), 32'd0);
        end
        reset_n = 1'b1;
        tick();
        chk_out("rel", 8'hA5, 8'hFF, 1'b0, 1'b0);

        wr_step(0, 8'h01, 8'hFF, 16'd3);
        wr_step(1, 8'h02, 8'h0F, 16'd1);
        wr_step(2, 8'h03, 8'h00, 16'd0);
        chk_out("idle", 8'hA5, 8'hFF, 1'b0, 1'b0);

        // Test 2: one-shot; num_steps/loop changed mid-run must be ignored
        I_num_steps = 5'd3;
        I_loop = 1'b0;
        pulse_start();
        I_num_steps = 5'd1;
        I_loop = 1'b1;
        chk_out("t2.T1", 8'h01, 8'hFF, 1'b1, 1'b0);
        chk("t2.T1.step", 32'(O_step), 32'd0);
        tick(); chk_out("t2.T2", 8'h01, 8'hFF, 1'b1, 1'b0);
        tick(); chk_out("t2.T3", 8'h01, 8'hFF, 1'b1, 1'b0);
        tick(); chk_out("t2.T4", 8'h02, 8'h0F, 1'b1, 1'b0);
        chk("t2.T4.step", 32'(O_step), 32'd1);
        tick(); chk_out("t2.T5", 8'h03, 8'h00, 1'b1, 1'b0);
        chk("t2.T5.step", 32'(O_step), 32'd2);
        tick(); chk_out("t2.T6", 8'hA5, 8'hFF, 1'b0, 1'b1);
        tick(); chk_out("t2.T7", 8'hA5, 8'hFF, 1'b0, 1'b0);

        // Test 3: loop, stop at T+9
        I_num_steps = 5'd3;
        I_loop = 1'b1;
        pulse_start();
        chk_out("t3.T1", 8'h01, 8'hFF, 1'b1, 1'b0);
        tick(); tick();
        chk_out("t3.T3", 8'h01, 8'hFF, 1'b1, 1'b0);
        tick(); chk_out("t3.T4", 8'h02, 8'h0F, 1'b1, 1'b0);
        tick(); chk_out("t3.T5", 8'h03, 8'h00, 1'b1, 1'b0);
        tick(); chk_out("t3.T6", 8'h01, 8'hFF, 1'b1, 1'b0);
        chk("t3.T6.step", 32'(O_step), 32'd0);
        tick(); chk_out("t3.T7", 8'h01, 8'hFF, 1'b1, 1'b0);
        tick(); chk_out("t3.T8", 8'h01, 8'hFF, 1'b1, 1'b0);
        tick(); chk_out("t3.T9", 8'h02, 8'h0F, 1'b1, 1'b0);
        I_stop = 1'b1;
        tick();
        I_stop = 1'b0;
        chk_out("t3.T10", 8'hA5, 8'hFF, 1'b0, 1'b0);
        tick(); chk_out("t3.T11", 8'hA5, 8'hFF, 1'b0, 1'b0);

        // Test 4: start+stop in idle, start with zero steps, restart during run
        I_stop = 1'b1;
        pulse_start();
        I_stop = 1'b0;
        chk_out("t4.startstop", 8'hA5, 8'hFF, 1'b0, 1'b0);
        tick(); chk_out("t4.startstop2", 8'hA5, 8'hFF, 1'b0, 1'b0);
        I_num_steps = 5'd0;
        pulse_start();
        chk_out("t4.zero", 8'hA5, 8'hFF, 1'b0, 1'b0);
        tick(); chk_out("t4.zero2", 8'hA5, 8'hFF, 1'b0, 1'b0);
        I_num_steps = 5'd3;
        I_loop = 1'b0;
        pulse_start();
        chk_out("t4.T1", 8'h01, 8'hFF, 1'b1, 1'b0);
        tick();
        pulse_start();
        chk_out("t4.T3", 8'h01, 8'hFF, 1'b1, 1'b0);
        tick(); chk_out("t4.T4", 8'h02, 8'h0F, 1'b1, 1'b0);
        tick(); chk_out("t4.T5", 8'h03, 8'h00, 1'b1, 1'b0);
        tick(); chk_out("t4.T6", 8'hA5, 8'hFF, 1'b0, 1'b1);

        // Test 5: rewrite step 1 while step 0 is on the outputs
        I_loop = 1'b1;
        pulse_start();
        chk_out("t5.T1", 8'h01, 8'hFF, 1'b1, 1'b0);
        wr_step(1, 8'h55, 8'hF0, 16'd2);
        chk_out("t5.T2", 8'h01, 8'hFF, 1'b1, 1'b0);
        tick(); chk_out("t5.T3", 8'h01, 8'hFF, 1'b1, 1'b0);
        tick(); chk_out("t5.T4", 8'h55, 8'hF0, 1'b1, 1'b0);
        chk("t5.T4.step", 32'(O_step), 32'd1);
        tick(); chk_out("t5.T5", 8'h55, 8'hF0, 1'b1, 1'b0);
        tick(); chk_out("t5.T6", 8'h03, 8'h00, 1'b1, 1'b0);
        tick(); chk_out("t5.T7", 8'h01, 8'hFF, 1'b1, 1'b0);
        I_stop = 1'b1;
        tick();
        I_stop = 1'b0;
        chk_out("t5.stop", 8'hA5, 8'hFF, 1'b0, 1'b0);

        // Test 6: num_steps beyond depth clamps to depth
        for (int i = 0; i < D; i++) begin
            wr_step(i, 8'(i + 8'h10), ~8'(i), 16'd1);
        end
        I_num_steps = 5'(D + 3);
        I_loop = 1'b0;
        pulse_start();
        for (int i = 0; i < D; i++) begin
            chk_out($sformatf("t6.s%0d", i), 8'(i + 8'h10), ~8'(i), 1'b1, 1'b0);
            chk($sformatf("t6.s%0d.step", i), 32'(O_step), 32'(i));
            tick();
        end
        chk_out("t6.end", 8'hA5, 8'hFF, 1'b0, 1'b1);
        tick(); chk_out("t6.after", 8'hA5, 8'hFF, 1'b0, 1'b0);

        // Reset in the middle of a running sequence
        I_num_steps = 5'd3;
        I_loop = 1'b1;
        pulse_start();
        tick();
        chk("mr.busy", 32'(O_busy), 32'd1);
        reset_n = 1'b0;
        tick();
        chk_out("mr.rst", 8'h00, 8'h00, 1'b0, 1'b0);
        chk("mr.step", 32'(O_step), 32'd0);
        reset_n = 1'b1;
        tick();
        chk_out("mr.rel", 8'hA5, 8'hFF, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
